data_bus_arbiter: RTL
=====================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of address paths.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of data paths.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports m0_req / m1_req  input  1  transfer request (m0 = core load/store, m1 = loader/debug), held until done or err.
REQ-007 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr / m1_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have ports m0_size / m1_size  input  2  00 byte, 01 half, 10 word.
REQ-010 SHALL have ports m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports m0_gnt / m1_gnt  output  1  master owns bus.
REQ-012 SHALL have ports m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports m0_err / m1_err  output  1  one-cycle timeout pulse.
REQ-014 SHALL have port rdata  output  DATA_WIDTH  registered read data, valid with done.
REQ-015 SHALL have ports bus_wd, bus_rd  output  1  one-cycle strobes to data bus control.
REQ-016 SHALL have ports bus_addr / bus_size / bus_wdata  output  ADDR_WIDTH / 2 / DATA_WIDTH  muxed from granted master.
REQ-017 SHALL have ports bus_ready, bus_busy  input  1  bus status; bus_rdata  input  DATA_WIDTH.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: any req -> select master, set its gnt, go ISSUE next cycle; no req -> stay.
REQ-020 Both req in IDLE: round-robin; winner = master not granted last; last_grant resets to 1 so m0 wins first tie.
REQ-021 Single req: that master wins regardless of last_grant.
REQ-022 ISSUE: when bus_ready=1 and bus_busy=0, pulse bus_wd (we=1) or bus_rd (we=0) for exactly one cycle, go WAIT; else stay ISSUE, no strobe.
REQ-023 bus_addr/size/wdata SHALL equal granted master's inputs in ISSUE and WAIT, all-zero otherwise.
REQ-024 WAIT: first cycle with bus_busy=0 -> register bus_rdata into rdata (reads only; writes leave rdata unchanged), go RESP.
REQ-025 RESP: pulse granted master's done one cycle, drop gnt, update last_grant, go IDLE.
REQ-026 Minimum latency req(IDLE, cycle 0) -> done = cycle 3 (ISSUE 1, WAIT 2, RESP 3).
REQ-027 8-bit wait counter cleared on WAIT entry, increments each WAIT cycle with bus_busy=1; reaching TIMEOUT -> pulse granted master's err, no done, drop gnt, update last_grant, go IDLE.
REQ-028 At most one gnt, one done, one err asserted in any cycle; done and err never together.
REQ-029 Granted master dropping req in ISSUE (before strobe): return to IDLE next cycle, no strobe, no done.
REQ-030 Req dropped after strobe ignored; transfer completes, done still pulses.
REQ-031 Other master's req during an active transfer SHALL be held off (no gnt) until RESP/abort completes; arbitration re-evaluated in IDLE.
REQ-032 Back-to-back: IDLE after RESP SHALL arbitrate same cycle it is entered; no extra idle cycle required beyond IDLE itself.

Reset
REQ-033 rst=1 at posedge: state IDLE, last_grant=1, counter=0, rdata=0, all gnt/done/err/bus_wd/bus_rd=0, bus_addr/size/wdata=0.
REQ-034 rst mid-transfer aborts silently: no done, no err; first cycle after rst release behaves as IDLE.

Verification
REQ-035 m0 read addr 0x100, size 10, bus_busy low, bus_rdata 0xDEADBEEF -> bus_rd pulse cycle 1, m0_done + rdata 0xDEADBEEF cycle 3.
REQ-036 m0 and m1 req same cycle after reset -> m0 served first, then m1 granted; repeat both -> m0 again (alternation).
REQ-037 m1 write 0x200 data 0x12345678, bus_ready=0 for 4 cycles in ISSUE -> no strobe until ready, single bus_wd, m1_done after WAIT.
REQ-038 m0 read, bus_busy stuck 1, TIMEOUT=15 -> m0_err pulse after 15 WAIT cycles, no m0_done, state IDLE.
REQ-039 rst asserted in WAIT -> no done/err, all outputs 0 next cycle; new m1 req served normally afterwards.
REQ-040 m0 drops req in ISSUE with bus_ready=0 -> no strobe, gnt low next cycle, m1 pending req granted from IDLE.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: round-robin grant, one bus command per transfer,
// wait for the bus to go idle, then complete or abort on timeout.
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [1:0]            m0_size,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [1:0]            m1_size,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_wd,
  output logic                  bus_rd,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [1:0]            bus_size,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic                  bus_busy,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t                r_state;
  state_t                w_next;
  logic                  r_sel;
  logic                  w_sel_next;
  logic                  r_last;
  logic                  r_we;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_req;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_size;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_strobe;
  logic                  w_timeout;
  logic                  w_active;

  assign w_req     = r_sel ? m1_req   : m0_req;
  assign w_we      = r_sel ? m1_we    : m0_we;
  assign w_addr    = r_sel ? m1_addr  : m0_addr;
  assign w_size    = r_sel ? m1_size  : m0_size;
  assign w_wdata   = r_sel ? m1_wdata : m0_wdata;
  assign w_timeout = (r_cnt == TIMEOUT_C);
  assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);

  // Next-state, arbitration and command strobe
  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    w_strobe   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_sel_next = ~r_last;
          w_next     = S_ISSUE;
        end else if (m0_req) begin
          w_sel_next = 1'b0;
          w_next     = S_ISSUE;
        end else if (m1_req) begin
          w_sel_next = 1'b1;
          w_next     = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        // An abandoned request before the strobe leaves last_grant untouched.
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (bus_ready && !bus_busy) begin
          w_strobe = 1'b1;
          w_next   = S_WAIT;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (w_timeout) begin
          w_next = S_IDLE;
        end else if (!bus_busy) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, wait counter and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_cnt   <= 8'd0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_sel <= w_sel_next;
      end
      if (w_strobe) begin
        r_we <= w_we;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 8'd0;
      end else if ((r_state == S_WAIT) && bus_busy && !w_timeout) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if ((r_state == S_WAIT) && !w_timeout && !bus_busy && !r_we) begin
        r_rdata <= bus_rdata;
      end
      if ((r_state == S_RESP) || ((r_state == S_WAIT) && w_timeout)) begin
        r_last <= r_sel;
      end
    end
  end

  assign m0_gnt    = (r_state != S_IDLE) && !r_sel;
  assign m1_gnt    = (r_state != S_IDLE) &&  r_sel;
  assign m0_done   = (r_state == S_RESP) && !r_sel;
  assign m1_done   = (r_state == S_RESP) &&  r_sel;
  assign m0_err    = (r_state == S_WAIT) && w_timeout && !r_sel;
  assign m1_err    = (r_state == S_WAIT) && w_timeout &&  r_sel;
  assign rdata     = r_rdata;
  assign bus_rd    = w_strobe && !w_we;
  assign bus_wd    = w_strobe &&  w_we;
  assign bus_addr  = w_active ? w_addr  : '0;
  assign bus_size  = w_active ? w_size  : 2'b00;
  assign bus_wdata = w_active ? w_wdata : '0;

endmodule
